pfd_loop_filter_nco: RTL and testbench
======================================

Name: pfd_loop_filter_nco

Overview:
Digital loop filter and numerically controlled oscillator (NCO). It consumes the single-cycle up/down pulses from the phase-frequency detector and generates the feedback clock clk_fb that returns to the detector. It is a proportional-integral filter driving a phase accumulator, with a lock detector. It shares the detector's clk/rst_n domain and joins its scan chain.

Parameters:
ACC_W, 16, phase accumulator width.
CTRL_W, 12, frequency control word width (unsigned).
KP, 4, proportional step applied for one cycle per pulse.
KI, 1, integral step per pulse.
FCW_INIT, 256, reset/centre control word; FCW_MIN < FCW_INIT < FCW_MAX.
FCW_MIN, 64, lower clamp.
FCW_MAX, 1023, upper clamp.
LOCK_CNT, 8, direction alternations required to declare lock.
UNLOCK_CNT, 4, consecutive same-direction pulses that drop lock.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous, active-low reset.
enable  in  1  loop run; 0 freezes all state.
up  in  1  detector up pulse (feedback lagging).
down  in  1  detector down pulse (feedback leading).
scan_en  in  1  scan shift enable; highest priority after reset.
scan_in  in  1  scan data in.
scan_out  out  1  scan data out = integ[CTRL_W-1].
clk_fb  out  1  generated feedback clock, registered.
fcw  out  CTRL_W  registered effective control word.
locked  out  1  lock indicator, registered.
sat  out  1  integ at FCW_MIN or FCW_MAX (combinational from register).

Behaviour:
- Reset values: integ=FCW_INIT, fcw=FCW_INIT, acc=0, clk_fb=0, locked=0, state=UNLOCKED, cnt=0, last_dir=NONE, sat=0, scan_out=FCW_INIT[CTRL_W-1].
- Priority per clk edge: scan_en, then enable=0, then normal operation.
- scan_en=1: integ <= {integ[CTRL_W-2:0], scan_in}. acc, fcw, clk_fb, FSM, cnt and last_dir hold. up/down are ignored.
- enable=0 (scan_en=0): all registers hold. up/down are ignored.
- Pulse decode: UP = up & ~down; DN = down & ~up. Both set or neither set means no pulse.
- Integral: on UP, integ <= min(integ+KI, FCW_MAX). On DN, integ <= max(integ-KI, FCW_MIN). Computation uses CTRL_W+1 bits, so there is no wrap.
- Effective word: fcw <= clamp(integ_next + (UP ? KP : DN ? -KP : 0), FCW_MIN, FCW_MAX). The result is a 1-cycle proportional kick. Latency: a pulse in cycle N appears on fcw after edge N, and fcw returns to integ after edge N+1 if no further pulse arrives.
- NCO: acc <= acc + fcw, modulo 2^ACC_W, using the registered fcw. clk_fb <= acc_next[ACC_W-1]. Output frequency = fcw * f_clk / 2^ACC_W.
- Lock FSM, evaluated only on a decoded pulse with enable=1 and scan_en=0. last_dir is always updated to the pulse direction.
  - UNLOCKED:
    - last_dir=NONE: cnt stays 0.
    - Pulse opposite to last_dir: cnt+1.
    - Pulse same as last_dir: cnt=0.
    - cnt+1 == LOCK_CNT: go to LOCKED, cnt=0, locked<=1.
  - LOCKED:
    - Pulse same as last_dir: cnt+1.
    - Pulse opposite to last_dir: cnt=0.
    - cnt+1 == UNLOCK_CNT: go to UNLOCKED, cnt=0, locked<=0.
- Saturation override: if integ_next equals FCW_MIN or FCW_MAX, the next state is UNLOCKED, cnt=0, locked<=0. This takes precedence over lock gain in the same cycle.
- Reset asserted mid-operation: all state returns to reset values immediately, and clk_fb drops to 0 asynchronously.
- cnt width is clog2(max(LOCK_CNT, UNLOCK_CNT)+1).

Test Plan:
1. Reset, then enable=1 with no pulses (defaults) -> fcw=256, clk_fb period 256 clk, high 128/low 128, first rise at clk_fb edge 128; locked=0, sat=0.
2. Single UP at cycle N -> fcw=261 after edge N, 257 after edge N+1 and holding; single DN thereafter -> fcw=252, then 256.
3. up=down=1 for 10 cycles, then enable=0 with up=1 for 10 cycles -> fcw=256 throughout; acc and clk_fb frozen during enable=0.
4. FCW_MAX=300: 44 UP pulses -> integ=300, sat=1, locked=0; 45th UP -> fcw stays 300 (clamped kick), integ stays 300; one DN -> sat=0, fcw=295 then 299.
5. 9 alternating pulses starting UP (LOCK_CNT=8) -> locked=1 one edge after 9th pulse; then 4 consecutive UP -> locked=0 one edge after 4th; an UP-UP-DN sequence while LOCKED -> stays locked.
6. scan_en=1, shift 12 bits of 0x155 MSB-first -> scan_out emits 0x100 MSB-first (FCW_INIT) and integ=0x155; scan_en=0, then one DN -> fcw=0x150, then 0x154.

Source files
------------

// File: rtl/pfd_loop_filter_nco_if.sv
// Control and observation bundle between the phase detector side and the
// loop filter / NCO.
interface pfd_loop_filter_nco_if #(
    parameter int CTRL_W = 12
);
    logic              enable;
    logic              up;
    logic              down;
    logic              scan_en;
    logic              scan_in;
    logic              scan_out;
    logic              clk_fb;
    logic [CTRL_W-1:0] fcw;
    logic              locked;
    logic              sat;

    modport master (
        output enable, up, down, scan_en, scan_in,
        input  scan_out, clk_fb, fcw, locked, sat
    );

    modport slave (
        input  enable, up, down, scan_en, scan_in,
        output scan_out, clk_fb, fcw, locked, sat
    );
endinterface

// File: rtl/pfd_loop_filter_nco.sv
// Proportional-integral loop filter driving a phase-accumulator NCO that
// produces the feedback clock, with a pulse-alternation lock detector.
module pfd_loop_filter_nco #(
    parameter int ACC_W      = 16,
    parameter int CTRL_W     = 12,
    parameter int KP         = 4,
    parameter int KI         = 1,
    parameter int FCW_INIT   = 256,
    parameter int FCW_MIN    = 64,
    parameter int FCW_MAX    = 1023,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pfd_loop_filter_nco_if.slave  pfd_if
);

    localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // Signed working width: one carry bit above CTRL_W plus a sign bit.
    localparam int SW      = CTRL_W + 2;

    localparam logic signed [SW-1:0] MIN_S  = SW'(FCW_MIN);
    localparam logic signed [SW-1:0] MAX_S  = SW'(FCW_MAX);
    localparam logic signed [SW-1:0] KP_S   = SW'(KP);
    localparam logic signed [SW-1:0] KI_S   = SW'(KI);
    localparam logic [CTRL_W-1:0]    MIN_U  = CTRL_W'(FCW_MIN);
    localparam logic [CTRL_W-1:0]    MAX_U  = CTRL_W'(FCW_MAX);
    localparam logic [CTRL_W-1:0]    INIT_U = CTRL_W'(FCW_INIT);

    typedef enum logic {UNLOCKED, LOCKED} state_e;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_e;

    function automatic logic [CTRL_W-1:0] clamp(input logic signed [SW-1:0] v,
                                                input logic lo_en, input logic hi_en);
        logic signed [SW-1:0] r;
        r = v;
        if (hi_en && (v > MAX_S)) r = MAX_S;
        if (lo_en && (v < MIN_S)) r = MIN_S;
        return r[CTRL_W-1:0];
    endfunction

    logic [CTRL_W-1:0]    integ_q, integ_d, fcw_q, fcw_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 clk_fb_q, clk_fb_d, locked_q, locked_d;
    state_e               state_q, state_d;
    dir_e                 dir_q, dir_d, dir_now;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                 pls_up, pls_dn, sat_nx;
    logic [CTRL_W-1:0]    integ_nx, fcw_nx;
    logic signed [SW-1:0] integ_s, kick_s;

    assign pls_up = pfd_if.up & ~pfd_if.down;
    assign pls_dn = pfd_if.down & ~pfd_if.up;

    // Filter arithmetic: integrator step and one-cycle proportional kick.
    always_comb begin
        integ_s  = $signed({2'b00, integ_q});
        integ_nx = integ_q;
        kick_s   = '0;
        dir_now  = DIR_NONE;
        if (pls_up) begin
            integ_nx = clamp(integ_s + KI_S, 1'b0, 1'b1);
            kick_s   = KP_S;
            dir_now  = DIR_UP;
        end else if (pls_dn) begin
            integ_nx = clamp(integ_s - KI_S, 1'b1, 1'b0);
            kick_s   = -KP_S;
            dir_now  = DIR_DN;
        end
        fcw_nx = clamp($signed({2'b00, integ_nx}) + kick_s, 1'b1, 1'b1);
        sat_nx = (integ_nx == MIN_U) || (integ_nx == MAX_U);
    end

    always_comb begin
        integ_d  = integ_q;
        fcw_d    = fcw_q;
        acc_d    = acc_q;
        clk_fb_d = clk_fb_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        locked_d = locked_q;
        cnt_inc  = cnt_q + CNT_W'(1);
        if (pfd_if.scan_en) begin
            integ_d = {integ_q[CTRL_W-2:0], pfd_if.scan_in};
        end else if (pfd_if.enable) begin
            integ_d  = integ_nx;
            fcw_d    = fcw_nx;
            acc_d    = acc_q + ACC_W'(fcw_q);
            clk_fb_d = acc_d[ACC_W-1];
            if (pls_up || pls_dn) begin
                dir_d = dir_now;
                case (state_q)
                    UNLOCKED: begin
                        if ((dir_q != DIR_NONE) && (dir_q != dir_now)) begin
                            if (cnt_inc == CNT_W'(LOCK_CNT)) begin
                                state_d  = LOCKED;
                                cnt_d    = '0;
                                locked_d = 1'b1;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end else begin
                            cnt_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (dir_q == dir_now) begin
                            if (cnt_inc == CNT_W'(UNLOCK_CNT)) begin
                                state_d  = UNLOCKED;
                                cnt_d    = '0;
                                locked_d = 1'b0;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end else begin
                            cnt_d = '0;
                        end
                    end
                    default: ;
                endcase
            end
            // A pinned integrator means the loop cannot track, so it wins over lock gain.
            if (sat_nx) begin
                state_d  = UNLOCKED;
                cnt_d    = '0;
                locked_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ_q  <= INIT_U;
            fcw_q    <= INIT_U;
            acc_q    <= '0;
            clk_fb_q <= 1'b0;
            locked_q <= 1'b0;
            state_q  <= UNLOCKED;
            cnt_q    <= '0;
            dir_q    <= DIR_NONE;
        end else begin
            integ_q  <= integ_d;
            fcw_q    <= fcw_d;
            acc_q    <= acc_d;
            clk_fb_q <= clk_fb_d;
            locked_q <= locked_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
        end
    end

    assign pfd_if.fcw      = fcw_q;
    assign pfd_if.clk_fb   = clk_fb_q;
    assign pfd_if.locked   = locked_q;
    assign pfd_if.sat      = (integ_q == MIN_U) || (integ_q == MAX_U);
    assign pfd_if.scan_out = integ_q[CTRL_W-1];

endmodule

// File: tb/tb_pfd_loop_filter_nco.sv
// Directed bench for pfd_loop_filter_nco: expectations are queued by cycle
// tag and a monitor compares them against the DUT outputs on falling edges.
module tb_pfd_loop_filter_nco;
    localparam int CTRL_W = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enable = 1'b0, up = 1'b0, down = 1'b0, scan_en = 1'b0, scan_in = 1'b0;

    always #5 clk = ~clk;

    pfd_loop_filter_nco_if #(.CTRL_W(CTRL_W)) bus0 ();
    pfd_loop_filter_nco_if #(.CTRL_W(CTRL_W)) bus1 ();

    assign bus0.enable = enable;  assign bus1.enable = enable;
    assign bus0.up = up;          assign bus1.up = up;
    assign bus0.down = down;      assign bus1.down = down;
    assign bus0.scan_en = scan_en; assign bus1.scan_en = scan_en;
    assign bus0.scan_in = scan_in; assign bus1.scan_in = scan_in;

    // dut0 uses default parameters; dut1 has a low upper clamp for saturation tests.
    pfd_loop_filter_nco u_dut0 (.clk(clk), .rst_n(rst_n), .pfd_if(bus0));
    pfd_loop_filter_nco #(.FCW_MAX(300)) u_dut1 (.clk(clk), .rst_n(rst_n), .pfd_if(bus1));

    typedef enum int {SIG_FCW, SIG_LOCK, SIG_SAT, SIG_CLK, SIG_SO} sig_e;
    typedef struct {
        int    cyc;
        int    sel;
        sig_e  sig;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sample(int sel, sig_e s);
        case (s)
            SIG_FCW:  return (sel != 0) ? int'(bus1.fcw)      : int'(bus0.fcw);
            SIG_LOCK: return (sel != 0) ? int'(bus1.locked)   : int'(bus0.locked);
            SIG_SAT:  return (sel != 0) ? int'(bus1.sat)      : int'(bus0.sat);
            SIG_CLK:  return (sel != 0) ? int'(bus1.clk_fb)   : int'(bus0.clk_fb);
            default:  return (sel != 0) ? int'(bus1.scan_out) : int'(bus0.scan_out);
        endcase
    endfunction

    task automatic expect_at(input int tag, input int sel, input sig_e s,
                             input int val, input string name);
        exp_t e;
        int   i;
        e.cyc = tag; e.sel = sel; e.sig = s; e.val = val; e.name = name;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > tag) i--;
        sb.insert(i, e);
    endtask

    // Monitor: outputs are stable at the falling edge, cyc counts rising edges seen.
    initial begin
        exp_t e;
        int   act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_chk++;
                if (e.cyc < cyc) begin
                    n_fail++;
                    $display("FAIL %s dut%0d: tag %0d not sampled (now %0d)", e.name, e.sel, e.cyc, cyc);
                end else begin
                    act = sample(e.sel, e.sig);
                    if (act != e.val) begin
                        n_fail++;
                        $display("FAIL %s dut%0d cyc %0d: got %0d, expected %0d",
                                 e.name, e.sel, cyc, act, e.val);
                    end
                end
            end
        end
    end

    task automatic tick(input logic u, input logic d);
        @(negedge clk);
        up = u;
        down = d;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0; up = 1'b0; down = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
        expect_at(cyc + 1, 0, SIG_FCW, 256, "rst_fcw");
        expect_at(cyc + 1, 0, SIG_LOCK, 0, "rst_locked");
        expect_at(cyc + 1, 0, SIG_SAT, 0, "rst_sat");
        expect_at(cyc + 1, 0, SIG_CLK, 0, "rst_clkfb");
        expect_at(cyc + 1, 0, SIG_SO, 0, "rst_scanout");
        expect_at(cyc + 1, 1, SIG_SAT, 0, "rst_sat");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int c0;
        logic [11:0] pat;
        logic [11:0] init_w;
        bit up_seq[24] = '{1,0,1,0,1,0,1,0,1, 1,1,1,1, 0,1,0,1,0,1,0,1, 1,1,0};
        bit lk_seq[24] = '{0,0,0,0,0,0,0,0,1, 1,1,1,0, 0,0,0,0,0,0,0,1, 1,1,1};

        // Free-running NCO at the centre word, then an asynchronous reset while clk_fb is high.
        do_reset();
        @(negedge clk);
        enable = 1'b1;
        c0 = cyc;
        expect_at(c0 + 1, 0, SIG_FCW, 256, "t1_fcw");
        expect_at(c0 + 1, 0, SIG_LOCK, 0, "t1_locked");
        expect_at(c0 + 1, 0, SIG_SAT, 0, "t1_sat");
        expect_at(c0 + 127, 0, SIG_CLK, 0, "t1_clk_127");
        expect_at(c0 + 128, 0, SIG_CLK, 1, "t1_clk_128");
        expect_at(c0 + 255, 0, SIG_CLK, 1, "t1_clk_255");
        expect_at(c0 + 256, 0, SIG_CLK, 0, "t1_clk_256");
        expect_at(c0 + 383, 0, SIG_CLK, 0, "t1_clk_383");
        expect_at(c0 + 384, 0, SIG_CLK, 1, "t1_clk_384");
        expect_at(c0 + 399, 0, SIG_CLK, 1, "t1_clk_399");
        wait_until(c0 + 400);
        rst_n = 1'b0;
        expect_at(cyc, 0, SIG_CLK, 0, "async_rst_clkfb");
        expect_at(cyc, 1, SIG_CLK, 0, "async_rst_clkfb");

        // Single proportional kicks up and down.
        do_reset();
        @(negedge clk);
        enable = 1'b1;
        tick(0, 0);
        tick(0, 0);
        tick(1, 0);
        c = cyc;
        expect_at(c + 1, 0, SIG_FCW, 261, "t2_up_kick");
        expect_at(c + 2, 0, SIG_FCW, 257, "t2_up_settle");
        expect_at(c + 4, 0, SIG_FCW, 257, "t2_up_hold");
        tick(0, 0); tick(0, 0); tick(0, 0);
        tick(0, 1);
        c = cyc;
        expect_at(c + 1, 0, SIG_FCW, 252, "t2_dn_kick");
        expect_at(c + 1, 0, SIG_SAT, 0, "t2_sat");
        expect_at(c + 2, 0, SIG_FCW, 256, "t2_dn_settle");
        expect_at(c + 2, 0, SIG_LOCK, 0, "t2_locked");
        tick(0, 0); tick(0, 0);

        // Simultaneous up/down is no pulse; enable=0 freezes the accumulator.
        do_reset();
        @(negedge clk);
        enable = 1'b1; up = 1'b1; down = 1'b1;
        c0 = cyc;
        for (int i = 1; i <= 20; i++) expect_at(c0 + i, 0, SIG_FCW, 256, "t3_fcw");
        expect_at(c0 + 20, 0, SIG_CLK, 0, "t3_clk_frozen");
        expect_at(c0 + 128, 0, SIG_CLK, 0, "t3_clk_128");
        expect_at(c0 + 137, 0, SIG_CLK, 0, "t3_clk_137");
        expect_at(c0 + 138, 0, SIG_CLK, 1, "t3_clk_138");
        repeat (10) @(negedge clk);
        enable = 1'b0; up = 1'b1; down = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b1; up = 1'b0;
        wait_until(c0 + 140);

        // Upper clamp on dut1 (FCW_MAX=300).
        do_reset();
        @(negedge clk);
        enable = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            tick(1, 0);
            if (i == 43) begin
                expect_at(cyc + 1, 1, SIG_FCW, 300, "t4_kick_clamp_43");
                expect_at(cyc + 1, 1, SIG_SAT, 0, "t4_sat_43");
            end else if (i == 44) begin
                expect_at(cyc + 1, 1, SIG_FCW, 300, "t4_fcw_44");
                expect_at(cyc + 1, 1, SIG_SAT, 1, "t4_sat_44");
                expect_at(cyc + 1, 1, SIG_LOCK, 0, "t4_locked_44");
                expect_at(cyc + 1, 0, SIG_FCW, 304, "t4_dut0_fcw_44");
                expect_at(cyc + 1, 0, SIG_SAT, 0, "t4_dut0_sat_44");
            end else if (i == 45) begin
                expect_at(cyc + 1, 1, SIG_FCW, 300, "t4_fcw_45");
                expect_at(cyc + 1, 1, SIG_SAT, 1, "t4_sat_45");
            end
        end
        tick(0, 1);
        expect_at(cyc + 1, 1, SIG_FCW, 295, "t4_dn_kick");
        expect_at(cyc + 1, 1, SIG_SAT, 0, "t4_dn_sat");
        tick(0, 0);
        expect_at(cyc + 1, 1, SIG_FCW, 299, "t4_dn_settle");
        tick(0, 0);

        // Lock acquisition, loss, re-acquisition and tolerance while locked.
        do_reset();
        @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick(up_seq[i], !up_seq[i]);
            expect_at(cyc + 1, 0, SIG_LOCK, int'(lk_seq[i]), $sformatf("t5_locked_p%0d", i + 1));
        end
        expect_at(cyc + 1, 0, SIG_FCW, 258, "t5_fcw_last");
        tick(0, 0);
        expect_at(cyc + 1, 0, SIG_FCW, 262, "t5_fcw_settle");
        expect_at(cyc + 1, 0, SIG_LOCK, 1, "t5_locked_idle");
        tick(0, 0);

        // Scan shift of 0x155 replaces the integrator; pulses during scan are ignored.
        do_reset();
        pat = 12'h155;
        init_w = 12'h100;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            enable = 1'b1; scan_en = 1'b1; up = 1'b1;
            scan_in = pat[11-k];
            if (k < 11)
                expect_at(cyc + 1, 0, SIG_SO, int'(init_w[10-k]), $sformatf("t6_scanout_%0d", k + 1));
            else
                expect_at(cyc + 1, 0, SIG_SO, int'(pat[11]), "t6_scanout_12");
            expect_at(cyc + 1, 0, SIG_FCW, 256, "t6_fcw_hold");
        end
        @(negedge clk);
        scan_en = 1'b0; up = 1'b0; down = 1'b1;
        expect_at(cyc + 1, 0, SIG_FCW, 'h150, "t6_dn_kick");
        expect_at(cyc + 2, 0, SIG_FCW, 'h154, "t6_dn_settle");
        tick(0, 0);
        tick(0, 0);

        if (sb.size() > 0) wait_until(sb[sb.size()-1].cyc + 1);
        @(negedge clk);
        @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL %s dut%0d: tag %0d never reached", e.name, e.sel, e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
